// File: rtl/reg_req_encoder.sv
// reg_req_encoder
// ---------------
// Registered 16-to-4 request encoder: the inverse of the register-enable decoder.
// It collects per-register request lines, latches them, and issues them one
// at a time as a 4-bit register index with a valid/ready handshake.
//
// Optional feature macro: REG_REQ_ENC_RR_EN
//   defined   -> round-robin selection starting at a rotating pointer
//   undefined -> fixed priority, lowest set index wins
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   req      in  16   request vector, bit i = one request for register i
//   clr      in   1   synchronous clear of pending and issued requests
//   ready    in   1   consumer accepts idx when valid && ready
//   idx      out  4   issued register index (registered)
//   valid    out  1   idx holds an issued request (registered)
//   pending  out 16   latched requests not yet issued (registered)
//   more     out  1   |pending (registered)

module reg_req_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        clr,
  input  logic        ready,
  output logic [3:0]  idx,
  output logic        valid,
  output logic [15:0] pending,
  output logic        more
);

  logic [15:0] cand;
  logic        slot_free;
  logic        found;
  logic [3:0]  sel;

  logic [3:0]  idx_nxt;
  logic        valid_nxt;
  logic [15:0] pending_nxt;

`ifdef REG_REQ_ENC_RR_EN
  logic [3:0]  ptr;
  logic [3:0]  ptr_nxt;
`endif

  assign cand      = pending | req;
  assign slot_free = !valid || ready;

  // Selection of one candidate bit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    sel   = 4'd0;
`ifdef REG_REQ_ENC_RR_EN
    // Walk upward from ptr with 4-bit wrap; first set bit wins.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] j;
      j = ptr + 4'(k);
      if (!found && cand[j]) begin
        found = 1'b1;
        sel   = j;
      end
    end
`else
    // Scan downward so the lowest set index is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (cand[i]) begin
        found = 1'b1;
        sel   = 4'(i);
      end
    end
`endif
  end

  // Next-state for the output slot and pending set.
  always_comb begin
    idx_nxt     = idx;
    valid_nxt   = valid;
    pending_nxt = cand;
`ifdef REG_REQ_ENC_RR_EN
    ptr_nxt     = ptr;
`endif
    if (clr) begin
      // Clear wins over everything: same-cycle req and any handshake are dropped.
      valid_nxt   = 1'b0;
      pending_nxt = 16'h0000;
`ifdef REG_REQ_ENC_RR_EN
      ptr_nxt     = 4'd0;
`endif
    end else if (slot_free) begin
      if (found) begin
        idx_nxt     = sel;
        valid_nxt   = 1'b1;
        pending_nxt = cand & ~(16'h0001 << sel);
`ifdef REG_REQ_ENC_RR_EN
        ptr_nxt     = sel + 4'd1;
`endif
      end else begin
        // Nothing to issue; idx keeps its last value.
        valid_nxt   = 1'b0;
        pending_nxt = 16'h0000;
      end
    end
    // Slot busy: requests merge into pending, idx/valid hold (defaults).
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= 4'd0;
      valid   <= 1'b0;
      pending <= 16'h0000;
      more    <= 1'b0;
`ifdef REG_REQ_ENC_RR_EN
      ptr     <= 4'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      idx     <= idx_nxt;
      valid   <= valid_nxt;
      pending <= pending_nxt;
      // more tracks the pending register itself, so it uses the same next value.
      more    <= |pending_nxt;
`ifdef REG_REQ_ENC_RR_EN
      ptr     <= ptr_nxt;
`endif
    end
  end

endmodule
